// File: rtl/ctrl_seq_pkg.sv
// Shared CPU package: operand-select, opcode, condition and sequencer state
// types, plus the EXEC-cycle strobe decode used by ctrl_seq.
package ctrl_seq_pkg;

    typedef enum logic [1:0] {
        DS_MEM = 2'b00,
        DS_IMM = 2'b01,
        DS_IND = 2'b10,
        DS_REG = 2'b11
    } data_src_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_ALU   = 3'b001,
        OP_ALUNC = 3'b010,
        OP_ST    = 3'b011,
        OP_JMP   = 3'b100,
        OP_CALL  = 3'b101,
        OP_RET   = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        CC_ALWAYS = 3'b000,
        CC_Z      = 3'b001,
        CC_NZ     = 3'b010,
        CC_CY     = 3'b011,
        CC_NCY    = 3'b100,
        CC_S      = 3'b101,
        CC_O      = 3'b110,
        CC_NO     = 3'b111
    } cond_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'b000,
        ST_DECODE = 3'b001,
        ST_MEMRD  = 3'b010,
        ST_EXEC   = 3'b011,
        ST_HALT   = 3'b100
    } state_t;

    typedef struct packed {
        logic cy;
        logic z;
        logic s;
        logic o;
    } flags_t;

    typedef struct packed {
        logic ce_a;
        logic ce_cy;
        logic mem_we;
        logic reg_we;
    } strobes_t;

    // Operand 00/10 select a memory operand, which costs an extra MEMRD cycle.
    function automatic logic needs_memrd(opcode_t opc, data_src_t ds);
        return ((opc == OP_ALU) || (opc == OP_ALUNC)) && (ds[0] == 1'b0);
    endfunction

    function automatic strobes_t exec_strobes(opcode_t opc, data_src_t ds);
        strobes_t s;
        s = '0;
        case (opc)
            OP_ALU: begin
                s.ce_a  = 1'b1;
                s.ce_cy = 1'b1;
            end
            OP_ALUNC: s.ce_a = 1'b1;
            OP_ST: begin
                if (ds == DS_REG) begin
                    s.reg_we = 1'b1;
                end else begin
                    s.mem_we = 1'b1;
                end
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ctrl_seq_cond_eval.sv
// Jump condition evaluator: maps a 3-bit condition code and the datapath
// flags to a single taken bit.
module cond_eval
    import ctrl_seq_pkg::*;
(
    input  cond_t  cond,
    input  flags_t flags,
    output logic   taken
);

    // Condition table lookup
    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_ALWAYS: taken = 1'b1;
            CC_Z:      taken = flags.z;
            CC_NZ:     taken = ~flags.z;
            CC_CY:     taken = flags.cy;
            CC_NCY:    taken = ~flags.cy;
            CC_S:      taken = flags.s;
            CC_O:      taken = flags.o;
            CC_NO:     taken = ~flags.o;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/MEMRD/EXEC/HALT control of
// a small accumulator datapath. Define CTRL_SEQ_CALL_EN to enable CALL/RET.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_data,
    input  logic                flag_cy,
    input  logic                flag_z,
    input  logic                flag_s,
    input  logic                flag_o,
    output data_src_t           data_src,
    output logic [WIDTH-1:0]    immediate,
    output logic [2:0]          op,
    output logic                ce_a,
    output logic                ce_cy,
    output logic [WIDTH-1:0]    mem_addr,
    output logic                mem_we,
    output logic [2:0]          reg_addr,
    output logic                reg_we,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted
);

    state_t              state_r;
    logic [PC_WIDTH-1:0] pc_r;
    logic [15:0]         ir_r;
    logic                halted_r;
    strobes_t            strobe_r;
`ifdef CTRL_SEQ_CALL_EN
    logic [PC_WIDTH-1:0] link_r;
`endif

    opcode_t             ir_opc_s;
    data_src_t           ir_ds_s;
    cond_t               ir_cond_s;
    opcode_t             dec_opc_s;
    data_src_t           dec_ds_s;
    flags_t              flags_s;
    logic                taken_s;
    logic [PC_WIDTH-1:0] pc_inc_s;
    logic [PC_WIDTH-1:0] pc_tgt_s;
    logic [PC_WIDTH-1:0] pc_next_s;

    assign ir_opc_s  = opcode_t'(ir_r[15:13]);
    assign ir_cond_s = cond_t'(ir_r[12:10]);
    assign ir_ds_s   = data_src_t'(ir_r[9:8]);
    // IR is not loaded until the end of DECODE, so the branch out of DECODE
    // looks at the instruction word straight from memory.
    assign dec_opc_s = opcode_t'(imem_data[15:13]);
    assign dec_ds_s  = data_src_t'(imem_data[9:8]);
    assign flags_s   = {flag_cy, flag_z, flag_s, flag_o};
    assign pc_inc_s  = pc_r + PC_WIDTH'(1);
    assign pc_tgt_s  = PC_WIDTH'(ir_r[7:0]);

    cond_eval u_cond_eval (
        .cond  (ir_cond_s),
        .flags (flags_s),
        .taken (taken_s)
    );

    // Next program counter, applied only at the end of EXEC
    always_comb begin
        pc_next_s = pc_inc_s;
        case (ir_opc_s)
            OP_JMP: begin
                if (taken_s) begin
                    pc_next_s = pc_tgt_s;
                end else begin
                    pc_next_s = pc_inc_s;
                end
            end
`ifdef CTRL_SEQ_CALL_EN
            OP_CALL: pc_next_s = pc_tgt_s;
            OP_RET:  pc_next_s = link_r;
`endif
            default: pc_next_s = pc_inc_s;
        endcase
    end

    // Sequencer FSM; strobes are registered on entry to EXEC so they last one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_FETCH;
            pc_r     <= '0;
            ir_r     <= 16'h0000;
            halted_r <= 1'b0;
            strobe_r <= '0;
`ifdef CTRL_SEQ_CALL_EN
            link_r   <= '0;
`endif
        end else begin
            strobe_r <= '0;
            case (state_r)
                ST_FETCH: state_r <= ST_DECODE;
                ST_DECODE: begin
                    ir_r <= imem_data;
                    if (needs_memrd(dec_opc_s, dec_ds_s)) begin
                        state_r <= ST_MEMRD;
                    end else if (dec_opc_s == OP_HALT) begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                    end else begin
                        state_r  <= ST_EXEC;
                        strobe_r <= exec_strobes(dec_opc_s, dec_ds_s);
                    end
                end
                ST_MEMRD: begin
                    state_r  <= ST_EXEC;
                    strobe_r <= exec_strobes(ir_opc_s, ir_ds_s);
                end
                ST_EXEC: begin
                    pc_r    <= pc_next_s;
                    state_r <= ST_FETCH;
`ifdef CTRL_SEQ_CALL_EN
                    if (ir_opc_s == OP_CALL) begin
                        link_r <= pc_inc_s;
                    end
`endif
                end
                ST_HALT: begin
                    state_r  <= ST_HALT;
                    halted_r <= 1'b1;
                end
                default: state_r <= ST_FETCH;
            endcase
        end
    end

    assign imem_addr = pc_r;
    assign pc        = pc_r;
    assign halted    = halted_r;
    assign op        = ir_r[12:10];
    assign data_src  = ir_ds_s;
    assign immediate = WIDTH'(ir_r[7:0]);
    assign mem_addr  = WIDTH'(ir_r[7:0]);
    assign reg_addr  = ir_r[2:0];
    assign ce_a      = strobe_r.ce_a;
    assign ce_cy     = strobe_r.ce_cy;
    assign mem_we    = strobe_r.mem_we;
    assign reg_we    = strobe_r.reg_we;

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data width of the immediate and memory address.
REQ-002 SHALL have parameter PC_WIDTH, default 8, giving the program counter width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports imem_addr  out  PC_WIDTH  instruction address; imem_data  in  16  instruction word, returned 1 cycle after imem_addr.
REQ-006 SHALL have ports flag_cy, flag_z, flag_s, flag_o  in  1 each  carry, zero, sign and overflow flags from the datapath.
REQ-007 SHALL have ports data_src  out  data_src_t  ALU operand select; immediate  out  WIDTH  immediate operand; op  out  3  ALU operation; ce_a  out  1  accumulator/flag enable; ce_cy  out  1  carry enable.
REQ-008 SHALL have ports mem_addr  out  WIDTH  data memory address; mem_we  out  1  store accumulator to memory; reg_addr  out  3  register index; reg_we  out  1  store accumulator to register.
REQ-009 SHALL have ports pc  out  PC_WIDTH  current program counter; halted  out  1  sequencer stopped.

Function
REQ-010 SHALL decode the latched instruction register IR as: [15:13] opcode, [12:10] alu op or condition, [9:8] data_src, [7:0] imm/address; reg index is IR[2:0].
REQ-011 SHALL implement opcodes 000 NOP, 001 ALU, 010 ALUNC (ALU without carry update), 011 ST, 100 JMP, 101 CALL, 110 RET, 111 HALT.
REQ-012 SHALL use FSM states FETCH, DECODE, MEMRD, EXEC, HALT, with transitions FETCH->DECODE; DECODE->MEMRD for ALU/ALUNC with data_src[0]=0; DECODE->HALT for HALT; DECODE->EXEC otherwise; MEMRD->EXEC; EXEC->FETCH; HALT->HALT.
REQ-013 SHALL drive imem_addr=pc in FETCH and latch imem_data into IR on the DECODE clock edge.
REQ-014 SHALL hold op=IR[12:10], data_src=IR[9:8], immediate=IR[7:0], mem_addr=IR[7:0] and reg_addr=IR[2:0] as Moore outputs from IR in every state.
REQ-015 SHALL assert ce_a for exactly one cycle in EXEC of ALU/ALUNC, and ce_cy in that same cycle for ALU only.
REQ-016 SHALL, for ST, assert reg_we in EXEC when IR[9:8]=11, and assert mem_we otherwise, for exactly one cycle.
REQ-017 SHALL, for JMP, evaluate condition IR[12:10] in EXEC: 000 always, 001 Z, 010 !Z, 011 CY, 100 !CY, 101 S, 110 O, 111 !O.
REQ-018 SHALL load pc with IR[7:0] at EXEC when a taken jump occurs, and with pc+1 otherwise; EXEC is the only pc update point.
REQ-019 SHALL give instruction latency of 3 cycles, or 4 cycles for ALU/ALUNC with a memory operand.
REQ-020 SHALL wrap pc modulo 2^PC_WIDTH, with 0xFF+1 giving 0x00 at the defaults.
REQ-021 SHALL, for HALT, assert halted continuously, keep all enables low, and freeze pc at the HALT address; only reset exits.
REQ-022 SHALL keep ce_a, ce_cy, mem_we and reg_we low in every state other than EXEC.

Reset
REQ-023 SHALL, while rst=0, immediately force state=FETCH, pc=0, IR=0 (NOP), link register=0 and halted=0, with all enables low.
REQ-024 SHALL, on reset asserted mid-instruction, abort the instruction with no partial enable pulse, and restart at FETCH of address 0 on the first edge after release.

Configuration
REQ-025 SHALL, with macro CTRL_SEQ_CALL_EN defined, implement CALL (link<=pc+1, pc<=IR[7:0] at EXEC) and RET (pc<=link at EXEC), using one non-nesting link register.
REQ-026 SHALL, without CTRL_SEQ_CALL_EN, execute CALL and RET as NOP (pc<=pc+1) and contain no link register.

Structure
REQ-027 SHALL take data_src_t, the opcode enum, the condition enum and the FSM state enum from the shared CPU package.
REQ-028 SHALL place condition evaluation in sub-module cond_eval (inputs cond, flags; output taken).

Verification
REQ-029 SHALL cover: ALU imm, IR=0x2105 -> op=000, data_src=01, immediate=0x05; ce_a and ce_cy high for exactly one cycle, 3 cycles after the fetch.
REQ-030 SHALL cover: ALUNC mem, IR=0x4010 -> MEMRD visited; ce_a high and ce_cy low in the 4th cycle; mem_addr=0x10.
REQ-031 SHALL cover: JMP Z to 0x40 with flag_z=1 -> pc=0x40; with flag_z=0 -> pc=old+1.
REQ-032 SHALL cover: pc=0xFF with NOP -> next pc=0x00.
REQ-033 SHALL cover: HALT at 0x07 -> halted=1, pc stays 0x07 for 20 cycles; rst pulse -> pc=0, halted=0.
REQ-034 SHALL cover: CALL 0x30 at 0x05 then RET -> pc=0x30 then 0x06 with CTRL_SEQ_CALL_EN defined; pc=0x06 after CALL without it.
